uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-stream frame parser that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes and delineates frames of the form header 0x55 0xAA, CMD, LEN, LEN payload bytes, CHK. Payload bytes stream out as they arrive, and a single end-of-frame status pulse reports success or the failure cause. An inter-byte timeout discards frames that stall mid-way.

## Interface
- p_MAX_LEN, 8'd16, largest accepted LEN; a larger LEN is a length error.
- p_TIMEOUT, 24'd434000, idle cycles allowed between bytes inside a frame (about 100 byte times at the 434-cycle baud divider).
- i_local_clk  in  1  single clock for the whole block.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  one-cycle byte strobe from the UART receiver.
- i_data  in  8  received byte; sampled only when i_valid=1.
- o_pl_valid  out  1  one-cycle strobe, one per payload byte.
- o_pl_data  out  8  payload byte.
- o_pl_idx  out  8  index of the payload byte within the frame, 0-based.
- o_cmd  out  8  CMD byte of the current frame; held until the next CMD is captured.
- o_len  out  8  LEN byte of the current frame; held until the next LEN is captured.
- o_done  out  1  one-cycle end-of-frame pulse.
- o_ok  out  1  qualifies o_done: 1 means the checksum is good; valid only while o_done=1, otherwise 0.
- o_err  out  2  qualifies o_done: 0 none, 1 checksum, 2 length, 3 timeout; 0 whenever o_done=0.

## Operation
- States:
  - S_HDR0: wait for 0x55.
  - S_HDR1: wait for 0xAA.
  - S_CMD, S_LEN: capture the CMD and LEN bytes.
  - S_PAYLOAD: stream payload bytes.
  - S_CHK: wait for the checksum byte.
- Transitions occur only on cycles with i_valid=1, except timeout and reset.
  - S_HDR0: 0x55 → S_HDR1; any other byte stays in S_HDR0.
  - S_HDR1: 0xAA → S_CMD; 0x55 stays in S_HDR1; any other byte → S_HDR0. No error is reported here.
  - S_CMD: capture o_cmd, clear the running sum, sum = CMD → S_LEN.
  - S_LEN: capture o_len and add it to the sum.
    - LEN > p_MAX_LEN → o_done, o_err=2, → S_HDR0.
    - LEN = 0 → S_CHK.
    - Otherwise → S_PAYLOAD.
  - S_PAYLOAD: output the byte with its index, add it to the sum, increment the byte count. The byte with index LEN-1 moves the FSM → S_CHK.
  - S_CHK: compute (sum + CHK) mod 256.
    - Result 0 → o_done, o_ok=1, o_err=0.
    - Otherwise → o_done, o_ok=0, o_err=1.
    - Either way → S_HDR0.
- Running sum is 8 bits and wraps modulo 256. The transmitter sets CHK = (−(CMD+LEN+Σpayload)) mod 256.
- Timeout:
  - A 24-bit counter clears on every i_valid and whenever the state is S_HDR0; otherwise it increments.
  - In S_HDR1, counter = p_TIMEOUT−1 with no byte returns the FSM silently to S_HDR0.
  - In S_CMD, S_LEN, S_PAYLOAD or S_CHK, the same condition gives o_done, o_err=3, → S_HDR0.
- Payload bytes of a failed frame have already been emitted. The consumer must discard them on o_ok=0.
- No backpressure: every i_valid byte is consumed.

## Timing
- o_pl_valid, o_pl_data and o_pl_idx are registered. They appear one cycle after the i_valid cycle of that byte.
- o_done/o_ok/o_err are registered and pulse one cycle after:
  - the CHK byte strobe,
  - the offending LEN strobe, or
  - the timeout cycle.
- A new 0x55 on the cycle right after a frame end is accepted. The FSM is back in S_HDR0 on that edge.
- A byte strobe and the timeout terminal count in the same cycle: the byte wins, it is processed normally and the counter clears.
- Reset mid-frame: on the next edge the state is S_HDR0 and the counter and sum are 0. o_pl_valid, o_done, o_ok, o_err, o_pl_data, o_pl_idx, o_cmd and o_len are all 0. No status pulse is generated for the aborted frame. i_valid is ignored while i_rst=1.
- Back-to-back i_valid on consecutive cycles must be handled (bench stress; the real UART spacing is about 4340 cycles).

## Test plan
- Good frame: 55 AA 01 02 10 20 CD.
  - Response: o_pl_valid twice, (0x10, idx 0) then (0x20, idx 1).
  - o_cmd=01, o_len=02.
  - One o_done with o_ok=1, o_err=0, one cycle after the CD strobe.
- Bad checksum: same frame with CHK=CE.
  - Response: both payload bytes emitted, then o_done with o_ok=0, o_err=1.
- Length error and zero length:
  - 55 AA 07 11 → o_done, o_err=2; no payload strobes.
  - Then 55 AA 07 00 F9 → o_done, o_ok=1, no payload strobes.
- Header resync: 55 55 AA 03 01 44 B8 → frame accepted, payload 0x44, o_ok=1. Preceding junk bytes 00 FF AA → no output.
- Timeout:
  - 55 AA 01 02 10 then silence → o_done, o_err=3 exactly p_TIMEOUT+1 cycles after the 0x10 strobe.
  - 55 then silence → no o_done.
  - A byte arriving on the terminal-count cycle suppresses the timeout.
- Reset mid-payload: assert i_rst for 1 cycle after 55 AA 01 03 10.
  - All outputs 0, no o_done.
  - A following good frame 55 AA 01 01 22 DC parses with o_ok=1.

Source files
------------

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - frame delineation for 55 AA CMD LEN payload CHK byte streams
module uart_frame_parser #(
    parameter logic [7:0]  p_MAX_LEN = 8'd16,
    parameter logic [23:0] p_TIMEOUT = 24'd434000
) (
    input  logic       i_local_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_pl_valid,
    output logic [7:0] o_pl_data,
    output logic [7:0] o_pl_idx,
    output logic [7:0] o_cmd,
    output logic [7:0] o_len,
    output logic       o_done,
    output logic       o_ok,
    output logic [1:0] o_err
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    state_t      state;
    logic [7:0]  sum;
    logic [7:0]  byte_cnt;
    logic [23:0] tmo_cnt;

    logic        tmo_hit;
    logic [7:0]  sum_next;

    // Terminal count of the inter-byte idle counter; a byte on the same cycle takes priority.
    assign tmo_hit  = (state != S_HDR0) && (tmo_cnt == p_TIMEOUT - 24'd1);
    assign sum_next = sum + i_data;

    // Frame FSM, running checksum, idle counter and all registered outputs.
    always_ff @(posedge i_local_clk) begin
        if (i_rst) begin
            state      <= S_HDR0;
            sum        <= 8'd0;
            byte_cnt   <= 8'd0;
            tmo_cnt    <= 24'd0;
            o_pl_valid <= 1'b0;
            o_pl_data  <= 8'd0;
            o_pl_idx   <= 8'd0;
            o_cmd      <= 8'd0;
            o_len      <= 8'd0;
            o_done     <= 1'b0;
            o_ok       <= 1'b0;
            o_err      <= ERR_NONE;
        end else begin
            o_pl_valid <= 1'b0;
            o_done     <= 1'b0;
            o_ok       <= 1'b0;
            o_err      <= ERR_NONE;

            if (i_valid || state == S_HDR0) begin
                tmo_cnt <= 24'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end

            if (i_valid) begin
                case (state)
                    S_HDR0: begin
                        if (i_data == 8'h55) begin
                            state <= S_HDR1;
                        end
                    end
                    S_HDR1: begin
                        if (i_data == 8'hAA) begin
                            state <= S_CMD;
                        end else if (i_data != 8'h55) begin
                            state <= S_HDR0;
                        end
                    end
                    S_CMD: begin
                        o_cmd <= i_data;
                        sum   <= i_data;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        o_len    <= i_data;
                        sum      <= sum_next;
                        byte_cnt <= 8'd0;
                        if (i_data > p_MAX_LEN) begin
                            o_done <= 1'b1;
                            o_err  <= ERR_LEN;
                            state  <= S_HDR0;
                        end else if (i_data == 8'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        o_pl_valid <= 1'b1;
                        o_pl_data  <= i_data;
                        o_pl_idx   <= byte_cnt;
                        sum        <= sum_next;
                        byte_cnt   <= byte_cnt + 8'd1;
                        if (byte_cnt == o_len - 8'd1) begin
                            state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        o_done <= 1'b1;
                        if (sum_next == 8'd0) begin
                            o_ok <= 1'b1;
                        end else begin
                            o_err <= ERR_CHK;
                        end
                        state <= S_HDR0;
                    end
                    default: begin
                        state <= S_HDR0;
                    end
                endcase
            end else if (tmo_hit) begin
                // A stalled header match is dropped quietly; a stalled frame body is reported.
                if (state != S_HDR1) begin
                    o_done <= 1'b1;
                    o_err  <= ERR_TMO;
                end
                state <= S_HDR0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;

    localparam logic [23:0] TO = 24'd50;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic [7:0] pl_idx;
    logic [7:0] cmd;
    logic [7:0] len;
    logic       done;
    logic       ok;
    logic [1:0] err;

    uart_frame_parser #(
        .p_MAX_LEN (8'd16),
        .p_TIMEOUT (TO)
    ) dut (
        .i_local_clk (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_data      (data),
        .o_pl_valid  (pl_valid),
        .o_pl_data   (pl_data),
        .o_pl_idx    (pl_idx),
        .o_cmd       (cmd),
        .o_len       (len),
        .o_done      (done),
        .o_ok        (ok),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        bit         is_done;
        logic [7:0] d;
        logic [7:0] idx;
        logic [7:0] c;
        logic [7:0] l;
        logic       ok;
        logic [1:0] err;
        int         edge_n;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_edge = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a payload byte or status pulse.
    always @(negedge clk) begin
        if (pl_valid || done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: pl_valid=%0b pl_data=%0h done=%0b err=%0d at edge %0d",
                         pl_valid, pl_data, done, err, edge_cnt);
            end else begin
                mon_e = q.pop_front();
                check("event_kind", {31'd0, done}, {31'd0, mon_e.is_done});
                check("event_edge", edge_cnt, mon_e.edge_n);
                if (mon_e.is_done) begin
                    check("done_ok", {31'd0, ok}, {31'd0, mon_e.ok});
                    check("done_err", {30'd0, err}, {30'd0, mon_e.err});
                    check("done_cmd", {24'd0, cmd}, {24'd0, mon_e.c});
                    check("done_len", {24'd0, len}, {24'd0, mon_e.l});
                end else begin
                    check("pl_data", {24'd0, pl_data}, {24'd0, mon_e.d});
                    check("pl_idx", {24'd0, pl_idx}, {24'd0, mon_e.idx});
                end
            end
        end
        if (!done) begin
            check("ok_idle", {31'd0, ok}, 32'd0);
            check("err_idle", {30'd0, err}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        valid     = 1'b1;
        data      = b;
        last_edge = edge_cnt + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic exp_pl(input logic [7:0] d, input logic [7:0] i);
        exp_t e;
        e.is_done = 1'b0;
        e.d       = d;
        e.idx     = i;
        e.c       = 8'd0;
        e.l       = 8'd0;
        e.ok      = 1'b0;
        e.err     = 2'd0;
        e.edge_n  = last_edge;
        q.push_back(e);
    endtask

    task automatic exp_done(input logic o, input logic [1:0] er, input logic [7:0] c,
                            input logic [7:0] l, input int at_edge);
        exp_t e;
        e.is_done = 1'b1;
        e.d       = 8'd0;
        e.idx     = 8'd0;
        e.c       = c;
        e.l       = l;
        e.ok      = o;
        e.err     = er;
        e.edge_n  = at_edge;
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pl_valid"}, {31'd0, pl_valid}, 32'd0);
        check({tag, "_pl_data"}, {24'd0, pl_data}, 32'd0);
        check({tag, "_pl_idx"}, {24'd0, pl_idx}, 32'd0);
        check({tag, "_cmd"}, {24'd0, cmd}, 32'd0);
        check({tag, "_len"}, {24'd0, len}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_ok"}, {31'd0, ok}, 32'd0);
        check({tag, "_err"}, {30'd0, err}, 32'd0);
    endtask

    initial begin
        int e_strobe;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Good frame, followed immediately by the same frame with a bad checksum.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); exp_pl(8'h10, 8'd0);
        send_byte(8'h20); exp_pl(8'h20, 8'd1);
        send_byte(8'hCD); exp_done(1'b1, 2'd0, 8'h01, 8'h02, last_edge);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); exp_pl(8'h10, 8'd0);
        send_byte(8'h20); exp_pl(8'h20, 8'd1);
        send_byte(8'hCE); exp_done(1'b0, 2'd1, 8'h01, 8'h02, last_edge);
        idle(3);

        // Length error, then a zero-length frame back to back.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h07);
        send_byte(8'h11); exp_done(1'b0, 2'd2, 8'h07, 8'h11, last_edge);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h07); send_byte(8'h00);
        send_byte(8'hF9); exp_done(1'b1, 2'd0, 8'h07, 8'h00, last_edge);
        idle(3);

        // Junk then header resync on a repeated 0x55.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hAA);
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h44); exp_pl(8'h44, 8'd0);
        send_byte(8'hB8); exp_done(1'b1, 2'd0, 8'h03, 8'h01, last_edge);
        idle(3);

        // Largest accepted length: 16 payload bytes 0..15, checksum 0x78.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            exp_pl(8'(i), 8'(i));
        end
        send_byte(8'h78); exp_done(1'b1, 2'd0, 8'h00, 8'h10, last_edge);
        idle(3);

        // Mid-payload stall times out TO+1 cycles after the last strobe.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); exp_pl(8'h10, 8'd0);
        e_strobe = last_edge;
        exp_done(1'b0, 2'd3, 8'h01, 8'h02, e_strobe + int'(TO));
        idle(int'(TO) + 5);

        // Stall after 0x55 returns silently; the stray tail must not parse as a frame.
        send_byte(8'h55);
        idle(int'(TO) + 10);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
        idle(3);

        // A byte landing on the terminal-count cycle wins over the timeout.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); exp_pl(8'h10, 8'd0);
        idle(int'(TO) - 1);
        send_byte(8'h20); exp_pl(8'h20, 8'd1);
        send_byte(8'hCD); exp_done(1'b1, 2'd0, 8'h01, 8'h02, last_edge);
        idle(3);

        // Reset mid-payload with a strobe asserted during reset.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03);
        send_byte(8'h10); exp_pl(8'h10, 8'd0);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h20;
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        check_all_zero("midreset");
        idle(int'(TO) + 5);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h22); exp_pl(8'h22, 8'd0);
        send_byte(8'hDC); exp_done(1'b1, 2'd0, 8'h01, 8'h01, last_edge);
        idle(10);

        check("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
